seq_divider_restoring: RTL
==========================

// Module: seq_divider_restoring
// PURPOSE
//   Sequential restoring divider: 2N-bit unsigned dividend / N-bit unsigned divisor -> 2N-bit quotient, N-bit remainder.
//   Inverse companion of the combinational array multiplier: for all legal inputs, dividend == quotient*divisor + remainder.
//   One quotient bit per clock; valid/ready handshake on both input and output sides.
//   Sits in the arithmetic datapath next to the multiplier; N=4 gives the 8-bit / 4-bit pairing.
// PARAMETERS
//   N        4    divisor/remainder width; dividend and quotient are 2N bits
// PORTS
//   clk           in   1    single clock, rising edge
//   rst_n         in   1    reset, asynchronous assert, active-low
//   in_valid      in   1    dividend/divisor valid
//   in_ready      out  1    block can accept operands (high only in IDLE)
//   dividend      in   2N   unsigned dividend, sampled on accept
//   divisor       in   N    unsigned divisor, sampled on accept
//   out_valid     out  1    result valid; held until consumed
//   out_ready     in   1    consumer accepts result
//   quotient      out  2N   unsigned quotient
//   remainder     out  N    unsigned remainder
//   div_by_zero   out  1    result produced from divisor == 0
// BEHAVIOUR
//   Reset (rst_n low, asynchronous): state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0.
//     Internal registers cleared; no partial result survives a reset, including a reset mid-RUN.
//   Accept: rising edge with in_valid && in_ready. Operands are registered; later input changes are ignored.
//   States:
//     IDLE: in_ready=1. On accept, divisor==0 -> DONE; otherwise -> RUN with cnt=0.
//     RUN:  in_ready=0; one iteration per edge; cnt counts 0..2N-1; after iteration 2N-1 -> DONE.
//     DONE: out_valid=1 and outputs stable. out_valid && out_ready at an edge -> IDLE (out_valid drops next cycle).
//   Iteration (restoring, MSB first):
//     partial remainder P is N+1 bits wide; shift P left and bring in the next dividend bit.
//     T = P - {1'b0,divisor}. If T >= 0: P=T, q_bit=1; else P unchanged, q_bit=0.
//     q_bit shifts into the quotient LSB.
//   Latency: for divisor!=0, out_valid rises on the 2N-th edge after the accept edge (8 for N=4).
//     For divisor==0, out_valid rises on the first edge after the accept edge.
//   Divide by zero: quotient={2N{1'b1}}; remainder=dividend[N-1:0]; div_by_zero=1.
//   div_by_zero is cleared on the next accept.
//   No bypass: in_ready stays 0 in RUN and DONE. A new operand cannot be accepted in the same cycle a result is consumed.
//     Throughput is 1 result per 2N+2 cycles, worst case.
//   Output registers change only on the transition into DONE. They hold their last value in IDLE until the next result.
//   in_valid while busy is ignored; the upstream holds its operands until in_ready.
//   out_ready while out_valid=0 has no effect.
//   Widths: counter is clog2(2N) bits; no overflow is possible for unsigned operands.
// STRUCTURE
//   Shared header arith_defs.vh: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default N, used by both the multiplier and the divider.
//   Sub-module div_step (combinational, parameter N):
//     in:  P, next dividend bit, divisor
//     out: new P, q_bit
//   Top level: FSM, iteration counter, operand/quotient shift registers, output registers.
// TESTING
//   1. 200/13 (N=4) -> 8 cycles after accept: out_valid=1, quotient=15, remainder=5, div_by_zero=0.
//   2. 255/1 -> quotient=255, remainder=0. 7/15 -> quotient=0, remainder=7. 0/5 -> quotient=0, remainder=0.
//   3. 100/0 -> 1 cycle after accept: quotient=255, remainder=4, div_by_zero=1. Next accept of 9/3 clears div_by_zero and gives quotient=3, remainder=0.
//   4. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
//      Outputs are stable and in_ready=0 throughout; in_valid pulses during this time are ignored.
//      Raising out_ready -> IDLE on the next edge.
//   5. Reset mid-RUN (assert rst_n=0 on cycle 3 of 200/13) -> immediately out_valid=0, in_ready=1, outputs=0.
//      A following 50/7 -> quotient=7, remainder=1.
//   6. Exhaustive sweep of all 4096 operand pairs, with out_ready randomised.
//      Compare against a / and % reference model, and check latency and handshake on every transaction.

Source files
------------

// File: rtl/seq_divider_restoring_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the controller state encoding and the default operand width, which the
// neighbouring array multiplier also uses.
package seq_divider_restoring_pkg;

  // Default divisor/remainder width. Dividend and quotient are twice this wide.
  parameter int unsigned DefaultN = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_restoring_div_step.sv
// One restoring-division iteration (combinational).
// Shifts the partial remainder left, brings in the next dividend bit, and
// subtracts the divisor when the result would not go negative.
//   p_i       : partial remainder before this step (N+1 bits, MSB always 0)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor
//   p_o       : partial remainder after this step
//   q_bit_o   : quotient bit produced by this step
module seq_divider_restoring_div_step #(
  parameter int unsigned N = 4
) (
  input  logic [N:0]   p_i,
  input  logic         bit_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   p_o,
  output logic         q_bit_o
);

  logic [N+1:0] p_shift;
  logic [N+1:0] diff;
  logic [N+1:0] p_next;

  always_comb begin
    p_shift = {p_i, bit_i};
    diff    = p_shift - {2'b00, divisor_i};
    q_bit_o = (p_shift >= {2'b00, divisor_i});
    p_next  = q_bit_o ? diff : p_shift;
    // The result is always below the divisor, so the top bit is always zero.
    p_o     = (N+1)'(p_next);
  end

endmodule

// File: rtl/seq_divider_restoring.sv
// Sequential restoring divider: 2N-bit unsigned dividend / N-bit divisor gives
// a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
// Ports:
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   in_valid_i     : operands valid
//   in_ready_o     : operands can be accepted (idle only)
//   dividend_i     : 2N-bit dividend, sampled on accept
//   divisor_i      : N-bit divisor, sampled on accept
//   out_valid_o    : result valid, held until consumed
//   out_ready_i    : consumer takes the result
//   quotient_o     : 2N-bit quotient
//   remainder_o    : N-bit remainder
//   div_by_zero_o  : result came from a zero divisor
module seq_divider_restoring
  import seq_divider_restoring_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [2*N-1:0] dividend_i,
  input  logic [N-1:0]   divisor_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*N-1:0] quotient_o,
  output logic [N-1:0]   remainder_o,
  output logic           div_by_zero_o
);

  localparam int unsigned CntW = $clog2(2 * N);
  localparam logic [CntW-1:0] CntLast = CntW'(2 * N - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]  dvd_q, dvd_d;       // dividend, shifted out MSB first
  logic [N-1:0]    dvs_q, dvs_d;
  logic [N:0]      p_q, p_d;           // partial remainder
  logic [2*N-1:0]  quo_q, quo_d;       // working quotient
  logic [2*N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]    remainder_q, remainder_d;
  logic            dbz_q, dbz_d;

  logic [N:0]      step_p;
  logic            step_q;

  seq_divider_restoring_div_step #(
    .N (N)
  ) u_div_step (
    .p_i       (p_q),
    .bit_i     (dvd_q[2*N-1]),
    .divisor_i (dvs_q),
    .p_o       (step_p),
    .q_bit_o   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    p_d         = p_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          p_d     = '0;
          quo_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        // A zero divisor spends exactly one RUN cycle, so its result appears
        // one edge after accept instead of 2N.
        if (dvs_q == '0) begin
          quotient_d  = '1;
          remainder_d = dvd_q[N-1:0];
          dbz_d       = 1'b1;
          state_d     = StDone;
        end else begin
          p_d   = step_p;
          quo_d = {quo_q[2*N-2:0], step_q};
          dvd_d = dvd_q << 1;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            quotient_d  = {quo_q[2*N-2:0], step_q};
            remainder_d = step_p[N-1:0];
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      p_q         <= p_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready_o    = (state_q == StIdle);
  assign out_valid_o   = (state_q == StDone);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule
